// File: rtl/mux_8_32_if.sv
// Byte-in / word-out bundle for the mux_8_32 byte-to-word packer.
// The master drives bytes; the slave (packer) returns words and status.
interface mux_8_32_if #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned CNT_W  = 16
);
    logic [BYTE_W-1:0]       data_in;
    logic                    valid;
    logic [BYTE_W*LANES-1:0] data_out;
    logic                    valid_out;
    logic                    partial_err;
    logic [CNT_W-1:0]        word_cnt;

    modport master (
        output data_in,
        output valid,
        input  data_out,
        input  valid_out,
        input  partial_err,
        input  word_cnt
    );

    modport slave (
        input  data_in,
        input  valid,
        output data_out,
        output valid_out,
        output partial_err,
        output word_cnt
    );
endinterface

// File: rtl/mux_8_32.sv
// Byte-to-word packer: gathers LANES consecutive valid bytes, first byte in the top lane,
// emits one word with a single-cycle valid pulse, and flags words cut short by a valid drop.
module mux_8_32 #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic        clk_4f,
    input logic        reset,
    mux_8_32_if.slave  bus
);
    localparam int unsigned WORD_W = BYTE_W * LANES;
    localparam int unsigned ACC_W  = BYTE_W * (LANES - 1);
    localparam int unsigned IDX_W  = $clog2(LANES);
    localparam logic [IDX_W-1:0] LastLane = IDX_W'(LANES - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              partial_err_q, partial_err_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    always_comb begin
        idx_d         = idx_q;
        acc_d         = acc_q;
        data_out_d    = data_out_q;
        valid_out_d   = 1'b0;
        partial_err_d = 1'b0;
        word_cnt_d    = word_cnt_q;
        if (bus.valid) begin
            if (idx_q == LastLane) begin
                // Final byte lands directly in the low lane of the output word.
                data_out_d  = {acc_q, bus.data_in};
                valid_out_d = 1'b1;
                word_cnt_d  = word_cnt_q + CNT_W'(1);
                idx_d       = '0;
                acc_d       = '0;
            end else begin
                for (int unsigned i = 0; i < LANES - 1; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        acc_d[(LANES-2-i)*BYTE_W +: BYTE_W] = bus.data_in;
                    end
                end
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (idx_q != '0) begin
            acc_d         = '0;
            idx_d         = '0;
            partial_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            idx_q         <= '0;
            acc_q         <= '0;
            data_out_q    <= '0;
            valid_out_q   <= 1'b0;
            partial_err_q <= 1'b0;
            word_cnt_q    <= '0;
        end else begin
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            data_out_q    <= data_out_d;
            valid_out_q   <= valid_out_d;
            partial_err_q <= partial_err_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign bus.data_out    = data_out_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.partial_err = partial_err_q;
    assign bus.word_cnt    = word_cnt_q;
endmodule

// File: tb/tb_mux_8_32.sv
// Scoreboard bench for mux_8_32: a default build and a CNT_W=4 build share one byte stream;
// the driver queues expected events, a negedge monitor checks every cycle against them.
module tb_mux_8_32;
    logic clk_4f = 1'b0;
    logic reset;

    always #5 clk_4f = ~clk_4f;

    mux_8_32_if #(.BYTE_W(8), .LANES(4), .CNT_W(16)) bus ();
    mux_8_32_if #(.BYTE_W(8), .LANES(4), .CNT_W(4))  bus4 ();

    assign bus4.data_in = bus.data_in;
    assign bus4.valid   = bus.valid;

    mux_8_32 #(.BYTE_W(8), .LANES(4), .CNT_W(16)) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    mux_8_32 #(.BYTE_W(8), .LANES(4), .CNT_W(4)) dut4 (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus4)
    );

    typedef struct {
        bit          is_word;
        logic [31:0] data;
        logic [15:0] cnt;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        rst_at_edge = 1'b1;
    logic [31:0] exp_hold = '0;
    logic [15:0] exp_cnt  = '0;

    always @(posedge clk_4f) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: outputs registered at the previous rising edge are sampled here.
    always @(negedge clk_4f) begin
        exp_t e;
        logic exp_vo;
        logic exp_pe;
        if (rst_at_edge) begin
            exp_hold = '0;
            exp_cnt  = '0;
            check("rst_data_out", bus.data_out, 32'h0);
            check("rst_valid_out", 32'(bus.valid_out), 32'h0);
            check("rst_partial_err", 32'(bus.partial_err), 32'h0);
            check("rst_word_cnt", 32'(bus.word_cnt), 32'h0);
            check("rst_word_cnt4", 32'(bus4.word_cnt), 32'h0);
        end else begin
            exp_vo = 1'b0;
            exp_pe = 1'b0;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check("sb_stale_entry", 32'(e.due), 32'(cyc));
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                exp_vo = e.is_word;
                exp_pe = !e.is_word;
                if (e.is_word) begin
                    exp_hold = e.data;
                    exp_cnt  = e.cnt;
                end
            end
            check("valid_out", 32'(bus.valid_out), 32'(exp_vo));
            check("partial_err", 32'(bus.partial_err), 32'(exp_pe));
            check("data_out", bus.data_out, exp_hold);
            check("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
            check("valid_out4", 32'(bus4.valid_out), 32'(exp_vo));
            check("data_out4", bus4.data_out, exp_hold);
            check("word_cnt4", 32'(bus4.word_cnt), 32'(exp_cnt[3:0]));
        end
    end

    task automatic step(input logic r, input logic v, input logic [7:0] b);
        @(posedge clk_4f);
        #1;
        reset        = r;
        bus.valid    = v;
        bus.data_in  = b;
    endtask

    task automatic push(input bit w, input logic [31:0] d, input logic [15:0] c);
        exp_t e;
        e.is_word = w;
        e.data    = d;
        e.cnt     = c;
        e.due     = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [15:0] c);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, w[31-8*i -: 8]);
        push(1'b1, w, c);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'hEE);
    endtask

    initial begin
        reset       = 1'b1;
        bus.valid   = 1'b0;
        bus.data_in = 8'h00;

        // Reset held while valid bytes stream in: everything must stay zero.
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h5A);
        step(1'b1, 1'b1, 8'hC3);
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'h01);

        // Back-to-back words, no bubble between them.
        send_word(32'hAABBCCDD, 16'd1);
        send_word(32'h11223344, 16'd2);
        idle(2);

        // Word cut short after two bytes.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h12);
        step(1'b0, 1'b1, 8'h34);
        step(1'b0, 1'b0, 8'h99);
        push(1'b0, 32'h0, 16'h0);
        send_word(32'h56789ABC, 16'd1);
        idle(1);

        // Single word then a long idle: data_out holds, no error.
        send_word(32'hDEADBEEF, 16'd2);
        idle(5);

        // Reset mid-word is silent; next byte starts a fresh word.
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        step(1'b1, 1'b0, 8'h00);
        send_word(32'h04050607, 16'd1);
        idle(1);

        // Reset coincides with the final byte: no word.
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        step(1'b1, 1'b1, 8'h04);
        idle(2);

        // 17 words: the 4-bit counter wraps 15 -> 0 -> 1.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b0;
            logic [7:0] b2;
            b0 = 8'(i);
            b2 = 8'(i * 3);
            send_word({b0, 8'hA5, b2, 8'h5A}, 16'(i + 1));
        end
        idle(3);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end
endmodule
